// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  // Frame-level states of the receiver.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Supported oversampling ratios; anything else falls back to the default.
  localparam int PRESCALE_8       = 8;
  localparam int PRESCALE_16      = 16;
  localparam int PRESCALE_32      = 32;
  localparam int DEFAULT_PRESCALE = PRESCALE_8;

  // True when the requested oversampling ratio is one the sampler supports.
  function automatic logic legal_prescale(input int value);
    return (value == PRESCALE_8) || (value == PRESCALE_16) || (value == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample (edge) counter and payload bit counter for one UART frame.
module uart_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale_q,
  input  logic                  count_bits,
  input  logic                  clear,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_end
);

  // Last oversample of the current bit; only meaningful while a frame is active.
  assign bit_end = enable && (edge_cnt == (prescale_q - PRESCALE_W'(1)));

  // Edge counter: held at zero when idle, wraps at the end of each bit.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!asy_reset) begin
      edge_cnt <= '0;
    end else if (!enable || bit_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  // Bit counter: advances once per payload bit, clear has priority.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (count_bits && bit_end) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences start/data/parity/stop bits,
// enables the bit-level checkers and reports the frame verdict as pulses.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  sampled_data_valid,
  input  logic                  start_glitch,
  input  logic                  parity_error,
  input  logic                  stop_error,
  output logic                  data_sample_enable,
  output logic                  start_check_enable,
  output logic                  deserializer_enable,
  output logic                  parity_check_enable,
  output logic                  stop_check_enable,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_e             state, next_state;
  logic [PRESCALE_W-1:0] prescale_q, prescale_load;
  logic                  load_prescale;
  logic                  bit_end, leaving_data;
  logic                  verdict, verdict_ok, err_q, err_now, late_q;
  logic                  par_fail_q, par_fail_d;
  logic                  data_valid_d, par_err_d, stp_err_d;

  // Enables are a pure decode of the current state.
  assign data_sample_enable  = (state != IDLE);
  assign start_check_enable  = (state == START);
  assign deserializer_enable = (state == DATA);
  assign parity_check_enable = (state == PARITY);
  assign stop_check_enable   = (state == STOP);

  uart_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .enable                (state != IDLE),
    .prescale_q            (prescale_q),
    .count_bits            (state == DATA),
    .clear                 ((state != DATA) || leaving_data),
    .edge_cnt              (edge_cnt),
    .bit_cnt               (bit_cnt),
    .bit_end               (bit_end)
  );

  // Unsupported ratios fall back to the default so a frame always has a sane bit length.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    prescale_load = PRESCALE_W'(DEFAULT_PRESCALE);
    if (legal_prescale(int'(prescale))) prescale_load = prescale;
  end

  // Pick the verdict of the checker that owns the current bit; a verdict from
  // a sample taken on the final oversample of a bit belongs to no bit and is dropped.
  always_comb begin
    verdict = 1'b0;
    case (state)
      START:   verdict = start_glitch;
      PARITY:  verdict = parity_error;
      STOP:    verdict = stop_error;
      default: verdict = 1'b0;
    endcase
    verdict_ok = verdict && !late_q;
    err_now    = err_q || verdict_ok;
  end

  // Next-state and frame-verdict logic.
  always_comb begin
    next_state    = state;
    load_prescale = 1'b0;
    leaving_data  = 1'b0;
    par_fail_d    = par_fail_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) begin
          next_state    = START;
          load_prescale = 1'b1;
        end
      end
      START: begin
        if (bit_end) next_state = err_now ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))) begin
          leaving_data = 1'b1;
          next_state   = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          next_state = STOP;
          if (err_now) begin
            par_err_d  = 1'b1;
            par_fail_d = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (err_now)          stp_err_d    = 1'b1;
          else if (!par_fail_q) data_valid_d = 1'b1;
          par_fail_d = 1'b0;
          // A low line at the stop boundary is already the next start bit.
          if (!rx_in) begin
            next_state    = START;
            load_prescale = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, prescale capture, checker flags and registered verdict pulses.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      state      <= IDLE;
      prescale_q <= '0;
      err_q      <= 1'b0;
      late_q     <= 1'b0;
      par_fail_q <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= next_state;
      late_q     <= sampled_data_valid && bit_end;
      par_fail_q <= par_fail_d;
      data_valid <= data_valid_d;
      par_err    <= par_err_d;
      stp_err    <= stp_err_d;
      if (load_prescale) prescale_q <= prescale_load;
      if (bit_end)         err_q <= 1'b0;
      else if (verdict_ok) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for the UART receive frame controller (prescale 8, 8 data bits).
module tb_uart_rx_fsm;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk_based_on_prescale = 1'b0;
  logic          asy_reset;
  logic          rx_in;
  logic          par_en;
  logic [PW-1:0] prescale;
  logic          sampled_data_valid = 1'b0;
  logic          start_glitch = 1'b0;
  logic          parity_error = 1'b0;
  logic          stop_error = 1'b0;
  logic          data_sample_enable, start_check_enable, deserializer_enable;
  logic          parity_check_enable, stop_check_enable;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          data_valid, par_err, stp_err;

  logic inject_perr = 1'b0;
  logic inject_serr = 1'b0;
  logic rx_at_sample = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle history: index k = outputs seen just after posedge N+k.
  logic          h_dv[256], h_pe[256], h_se[256], h_dse[256];
  logic          h_sce[256], h_des[256], h_pce[256], h_stce[256];
  logic [PW-1:0] h_edge[256];
  logic [BW-1:0] h_bit[256];
  int            n_dv, n_pe, n_se, n_des;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .rx_in                 (rx_in),
    .par_en                (par_en),
    .prescale              (prescale),
    .sampled_data_valid    (sampled_data_valid),
    .start_glitch          (start_glitch),
    .parity_error          (parity_error),
    .stop_error            (stop_error),
    .data_sample_enable    (data_sample_enable),
    .start_check_enable    (start_check_enable),
    .deserializer_enable   (deserializer_enable),
    .parity_check_enable   (parity_check_enable),
    .stop_check_enable     (stop_check_enable),
    .edge_cnt              (edge_cnt),
    .bit_cnt               (bit_cnt),
    .data_valid            (data_valid),
    .par_err               (par_err),
    .stp_err               (stp_err)
  );

  always #5 clk_based_on_prescale = ~clk_based_on_prescale;

  // Sampler and checker models: sample pulse at edge_cnt=4, verdict one cycle later.
  always @(negedge clk_based_on_prescale) begin
    start_glitch       = sampled_data_valid && start_check_enable && rx_at_sample;
    parity_error       = sampled_data_valid && parity_check_enable && inject_perr;
    stop_error         = sampled_data_valid && stop_check_enable && inject_serr;
    sampled_data_valid = data_sample_enable && (edge_cnt == PW'(4));
  end

  always @(posedge clk_based_on_prescale)
    if (sampled_data_valid) rx_at_sample <= rx_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic record(input int k);
    h_dv[k]   = data_valid;
    h_pe[k]   = par_err;
    h_se[k]   = stp_err;
    h_dse[k]  = data_sample_enable;
    h_sce[k]  = start_check_enable;
    h_des[k]  = deserializer_enable;
    h_pce[k]  = parity_check_enable;
    h_stce[k] = stop_check_enable;
    h_edge[k] = edge_cnt;
    h_bit[k]  = bit_cnt;
    n_dv  += int'(data_valid);
    n_pe  += int'(par_err);
    n_se  += int'(stp_err);
    n_des += int'(deserializer_enable);
  endtask

  // Drive a bit stream (LSB first, 8 cycles per bit) starting from idle.
  // Posedge N is the first edge that sees bits[0].
  task automatic run_frame(input logic [31:0] bits, input int cycles,
                           input logic glitch, input int reset_at);
    logic aborted;
    aborted = 1'b0;
    n_dv = 0; n_pe = 0; n_se = 0; n_des = 0;
    for (int j = 0; j <= cycles; j++) begin
      @(negedge clk_based_on_prescale);
      if (j > 0) record(j - 1);
      if (j == reset_at) begin
        asy_reset = 1'b0;
        #1;
        check("reset_outputs_zero",
              {18'd0, data_valid, par_err, stp_err, data_sample_enable, edge_cnt, bit_cnt}, 32'd0);
        #1;
        asy_reset = 1'b1;
        aborted = 1'b1;
      end
      if (aborted || (j / 8) >= 32) rx_in = 1'b1;
      else                          rx_in = bits[j / 8];
      if (glitch && j >= 3 && j < 8) rx_in = 1'b1;
    end
    rx_in = 1'b1;
  endtask

  localparam logic [31:0] FRAME_A5    = {22'h3FFFFF, 1'b1, 8'hA5, 1'b0};
  localparam logic [31:0] FRAME_A5_P  = {21'h1FFFFF, 1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [31:0] FRAME_B2B   = {12'hFFF, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [31:0] FRAME_START = 32'hFFFF_FFFE;

  initial begin
    int late_dse;
    asy_reset = 1'b0;
    rx_in     = 1'b1;
    par_en    = 1'b0;
    prescale  = PW'(8);
    repeat (2) @(negedge clk_based_on_prescale);
    check("in_reset",
          {18'd0, data_valid, par_err, stp_err, data_sample_enable, edge_cnt, bit_cnt}, 32'd0);
    asy_reset = 1'b1;
    repeat (3) @(negedge clk_based_on_prescale);
    check("idle_after_reset", {31'd0, data_sample_enable}, 32'd0);

    // Clean 0xA5 frame, no parity.
    run_frame(FRAME_A5, 96, 1'b0, -1);
    check("clean_start_entered", {30'd0, h_dse[0], h_sce[0]}, 32'd3);
    check("clean_edge0", 32'(h_edge[0]), 32'd0);
    check("clean_edge7", 32'(h_edge[7]), 32'd7);
    check("clean_data_entered", {31'd0, h_des[8]}, 32'd1);
    check("clean_bit7", 32'(h_bit[71]), 32'd7);
    check("clean_stop_bit0", {28'd0, h_stce[72], h_bit[72][2:0]}, 32'h8);
    check("clean_dv_before", {31'd0, h_dv[79]}, 32'd0);
    check("clean_dv_at_80", {31'd0, h_dv[80]}, 32'd1);
    check("clean_idle_at_80", {31'd0, h_dse[80]}, 32'd0);
    check("clean_dv_count", 32'(n_dv), 32'd1);
    check("clean_err_count", 32'(n_pe + n_se), 32'd0);

    // Start glitch: line returns high early in the start bit.
    run_frame(FRAME_START, 24, 1'b1, -1);
    check("glitch_start_held", {31'd0, h_dse[7]}, 32'd1);
    check("glitch_idle_at_8", {31'd0, h_dse[8]}, 32'd0);
    check("glitch_no_data", 32'(n_des), 32'd0);
    check("glitch_no_pulses", 32'(n_dv + n_pe + n_se), 32'd0);

    // Parity error.
    par_en = 1'b1; inject_perr = 1'b1;
    run_frame(FRAME_A5_P, 104, 1'b0, -1);
    par_en = 1'b0; inject_perr = 1'b0;
    check("par_parity_entered", {31'd0, h_pce[72]}, 32'd1);
    check("par_err_at_80", {31'd0, h_pe[80]}, 32'd1);
    check("par_err_count", 32'(n_pe), 32'd1);
    check("par_stop_end", {30'd0, h_dse[87], h_dse[88]}, 32'd2);
    check("par_no_dv", 32'(n_dv), 32'd0);
    check("par_no_stp", 32'(n_se), 32'd0);

    // Stop error.
    inject_serr = 1'b1;
    run_frame(FRAME_A5, 96, 1'b0, -1);
    inject_serr = 1'b0;
    check("stp_err_at_80", {31'd0, h_se[80]}, 32'd1);
    check("stp_err_count", 32'(n_se), 32'd1);
    check("stp_no_dv", 32'(n_dv), 32'd0);

    // Back-to-back frames.
    run_frame(FRAME_B2B, 176, 1'b0, -1);
    check("b2b_no_idle", {29'd0, h_dse[80], h_sce[80], h_dv[80]}, 32'd7);
    check("b2b_edge_restart", 32'(h_edge[80]), 32'd0);
    check("b2b_dv_at_160", {31'd0, h_dv[160]}, 32'd1);
    check("b2b_idle_at_160", {31'd0, h_dse[160]}, 32'd0);
    check("b2b_dv_count", 32'(n_dv), 32'd2);

    // Reset at edge_cnt=3 of data bit 4.
    run_frame(FRAME_A5, 70, 1'b0, 44);
    check("rst_pre_edge", 32'(h_edge[43]), 32'd3);
    check("rst_pre_bit", 32'(h_bit[43]), 32'd4);
    late_dse = 0;
    for (int k = 44; k < 70; k++) late_dse += int'(h_dse[k]);
    check("rst_stays_idle", 32'(late_dse), 32'd0);
    check("rst_no_pulses", 32'(n_dv + n_pe + n_se), 32'd0);

    // Fresh frame after reset.
    run_frame(FRAME_A5, 96, 1'b0, -1);
    check("fresh_dv_at_80", {31'd0, h_dv[80]}, 32'd1);
    check("fresh_dv_count", 32'(n_dv), 32'd1);

    // Illegal prescale falls back to 8.
    prescale = PW'(5);
    run_frame(FRAME_A5, 96, 1'b0, -1);
    check("ps5_edge7", 32'(h_edge[7]), 32'd7);
    check("ps5_data_at_8", {31'd0, h_des[8]}, 32'd1);
    check("ps5_dv_at_80", {31'd0, h_dv[80]}, 32'd1);
    check("ps5_dv_count", 32'(n_dv), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
